// File: rtl/pwm_stim_gen.sv
// PWM stimulus generator for real-number emulation.
// Produces a digital PWM bit plus a matching signed fixed-point level.
// The waveform advances one timestep per enabled cycle. New period/high-time
// settings are held in a single pending slot and become active only at a
// period wrap, so a running period is never cut short or stretched.
module pwm_stim_gen #(
  parameter int                             CNT_WIDTH  = 16,
  parameter int                             OUT_WIDTH  = 18,
  parameter logic signed [OUT_WIDTH-1:0]    HI_VAL     = 18'sd131071,
  parameter logic signed [OUT_WIDTH-1:0]    LO_VAL     = -18'sd131071,
  parameter logic        [CNT_WIDTH-1:0]    DEF_PERIOD = 16'd1000,
  parameter logic        [CNT_WIDTH-1:0]    DEF_HIGH   = 16'd500
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         cfg_valid,
  input  logic        [CNT_WIDTH-1:0]  cfg_period,
  input  logic        [CNT_WIDTH-1:0]  cfg_high,
  output logic                         cfg_ready,
  output logic                         out_dig,
  output logic signed [OUT_WIDTH-1:0]  out_real,
  output logic                         cycle_start
);

  // Reset-time settings, clamped the same way as runtime configurations.
  localparam logic [CNT_WIDTH-1:0] MIN_PER  = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] RST_PER  = (DEF_PERIOD < MIN_PER) ? MIN_PER : DEF_PERIOD;
  localparam logic [CNT_WIDTH-1:0] RST_HIGH = (DEF_HIGH > RST_PER) ? RST_PER : DEF_HIGH;

  logic [CNT_WIDTH-1:0]         r_cnt;
  logic [CNT_WIDTH-1:0]         r_per_act;
  logic [CNT_WIDTH-1:0]         r_high_act;
  logic [CNT_WIDTH-1:0]         r_per_pend;
  logic [CNT_WIDTH-1:0]         r_high_pend;
  logic                         r_pend;
  logic                         r_dig;
  logic signed [OUT_WIDTH-1:0]  r_real;
  logic                         r_cycle_start;

  logic [CNT_WIDTH-1:0]         w_per_m1;
  logic                         w_wrap;
  logic                         w_apply;
  logic                         w_accept;
  logic [CNT_WIDTH-1:0]         w_cnt_next;
  logic [CNT_WIDTH-1:0]         w_high_next;
  logic [CNT_WIDTH-1:0]         w_cfg_per;
  logic [CNT_WIDTH-1:0]         w_cfg_high;
  logic                         w_dig_next;

  // Next-state terms for the counter, the pending slot and the output bit.
  always_comb begin
    w_per_m1    = r_per_act - CNT_WIDTH'(1);
    w_wrap      = (r_cnt == w_per_m1);
    // Accept and apply are mutually exclusive (accept needs !pend, apply
    // needs pend), so a config taken on a wrap cycle waits for the next wrap.
    w_apply     = w_wrap && r_pend;
    w_accept    = cfg_valid && !r_pend;
    w_cnt_next  = w_wrap ? '0 : (r_cnt + CNT_WIDTH'(1));
    w_high_next = w_apply ? r_high_pend : r_high_act;
    w_cfg_per   = (cfg_period < MIN_PER) ? MIN_PER : cfg_period;
    w_cfg_high  = (cfg_high > w_cfg_per) ? w_cfg_per : cfg_high;
    // cnt_next never exceeds period-1, so high=0 gives constant 0 and
    // high=period gives constant 1 with no extra logic.
    w_dig_next  = (w_cnt_next < w_high_next);
  end

  // Waveform state, pending-config slot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_per_act     <= RST_PER;
      r_high_act    <= RST_HIGH;
      r_per_pend    <= RST_PER;
      r_high_pend   <= RST_HIGH;
      r_pend        <= 1'b0;
      r_dig         <= (RST_HIGH != '0);
      r_real        <= (RST_HIGH != '0) ? HI_VAL : LO_VAL;
      r_cycle_start <= 1'b0;
    end else begin
      r_cycle_start <= en && w_wrap;
      if (en) begin
        r_cnt  <= w_cnt_next;
        r_dig  <= w_dig_next;
        r_real <= w_dig_next ? HI_VAL : LO_VAL;
        if (w_apply) begin
          r_per_act  <= r_per_pend;
          r_high_act <= r_high_pend;
        end
      end
      if (w_accept) begin
        r_per_pend  <= w_cfg_per;
        r_high_pend <= w_cfg_high;
        r_pend      <= 1'b1;
      end else if (en && w_apply) begin
        r_pend      <= 1'b0;
      end
    end
  end

  assign cfg_ready   = !r_pend;
  assign out_dig     = r_dig;
  assign out_real    = r_real;
  assign cycle_start = r_cycle_start;

endmodule

// File: doc/pwm_stim_gen.md
PWM_STIM_GEN -- requirements
Module: pwm_stim_gen

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of period/high-time counters, in emulation timesteps.
REQ-002 Parameter OUT_WIDTH, default 18: width of signed fixed-point real output.
REQ-003 Parameter HI_VAL, default 18'sd131071: fixed-point level driven when digital output is high.
REQ-004 Parameter LO_VAL, default -18'sd131071: fixed-point level driven when digital output is low.
REQ-005 Parameter DEF_PERIOD, default 16'd1000: period after reset, in timesteps.
REQ-006 Parameter DEF_HIGH, default 16'd500: high time after reset, in timesteps.
REQ-007 clk  input  1  emulator clock, single domain; all state changes on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 en  input  1  timestep tick; the waveform advances one timestep per cycle with en=1.
REQ-010 cfg_valid  input  1  new period/high-time offered.
REQ-011 cfg_period  input  CNT_WIDTH  requested period, in timesteps.
REQ-012 cfg_high  input  CNT_WIDTH  requested high time, in timesteps.
REQ-013 cfg_ready  output  1  block can accept a configuration.
REQ-014 out_dig  output  1  registered PWM bit.
REQ-015 out_real  output  OUT_WIDTH  registered signed level, HI_VAL when out_dig=1, else LO_VAL.
REQ-016 cycle_start  output  1  one-cycle pulse when a new period begins.

Function
REQ-017 State: counter cnt, active per_act/high_act, pending per_pend/high_pend, pend flag.
REQ-018 A config transfer SHALL occur in any cycle with cfg_valid=1 and cfg_ready=1; it SHALL load the pending registers and set pend.
REQ-019 cfg_ready SHALL equal !pend; at most one pending config, with no overwrite.
REQ-020 On an en=1 cycle: if cnt==per_act-1, cnt SHALL become 0, else cnt+1.
REQ-021 On an en=1 cycle with cnt==per_act-1 and pend=1, the pending values SHALL become active, and pend SHALL clear in the same cycle.
REQ-022 If a new config is accepted in the same cycle as a wrap, it SHALL NOT apply at that wrap; pend SHALL remain 1.
REQ-023 Period clamp: a cfg_period below 2 SHALL be stored as 2.
REQ-024 High-time clamp: a cfg_high above the stored period SHALL be stored as that period.
REQ-025 On an en=1 cycle, out_dig SHALL register (cnt_next < high_next), using the values that are active after the update; latency is 1 cycle from tick.
REQ-026 When high_act=0, out_dig SHALL stay 0; when high_act=per_act, out_dig SHALL stay 1.
REQ-027 out_real SHALL be registered in the same cycle as out_dig and SHALL always agree with it.
REQ-028 cycle_start SHALL be 1 for exactly the cycle after an en=1 wrap, else 0.
REQ-029 When en=0, cnt, out_dig, out_real and the active registers SHALL hold; config acceptance SHALL still operate.

Reset
REQ-030 On rst=1 at a clock edge: cnt=0, per_act=max(DEF_PERIOD,2), high_act=min(DEF_HIGH,per_act), pend=0, cfg_ready=1, cycle_start=0.
REQ-031 After reset, out_dig SHALL be (high_act>0) and out_real the matching level.
REQ-032 rst SHALL override en and cfg_valid in the same cycle; a pending config SHALL be discarded.

Verification
REQ-033 Run with DEF_PERIOD=4, DEF_HIGH=2, en=1 constant after reset -> out_dig 1,1,0,0 repeating; out_real tracks HI_VAL/LO_VAL; cycle_start every 4th cycle.
REQ-034 Mid-period, offer cfg period=6, high=1 -> cfg_ready drops the next cycle; the old 4/2 pattern completes; then out_dig 1,0,0,0,0,0 follows; cfg_ready rises at the wrap.
REQ-035 Offer cfg high=0, then high=9 with period=5 -> out_dig constant 0, then constant 1 (high clamped to 5); period=0 runs as period 2.
REQ-036 en toggling 1,0,0,1 with period 4/high 2 -> outputs hold during en=0; the sequence is identical to the REQ-033 sequence counted in ticks only.
REQ-037 Assert rst while a config is pending, mid-period -> next cycle cnt=0, DEF values active, cfg_ready=1, out_dig=1.
REQ-038 Offer cfg_valid in the same cycle as a wrap -> it applies at the following wrap, not the current one.
